// File: rtl/registrador_leitor.sv
// registrador_leitor: read-side sequencer for the register bank.
// A start in IDLE snapshots every register word at once, then the words are
// streamed out one per accepted transfer (rd_valid/rd_ready) while a running
// sum and maximum are accumulated. done pulses once after the last word.
// Optional feature macro: READ_PARITY_EN (adds rd_par and par_err_cnt).
module registrador_leitor #(
    parameter int W    = 6,
    parameter int NREG = 3
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic [NREG*W-1:0] q_bus,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [1:0]        rd_idx,
    output logic [W-1:0]      rd_data,
    output logic              busy,
    output logic [W+1:0]      sum,
    output logic [W-1:0]      max,
    output logic              done,
`ifdef READ_PARITY_EN
    output logic              rd_par,
    output logic [3:0]        par_err_cnt,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: a word moves on a posedge where rd_valid && rd_ready are both
    // high; while rd_ready is low, rd_valid/rd_idx/rd_data stay unchanged.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(NREG - 1);

    state_t              r_state;
    state_t              w_next;
    logic [NREG*W-1:0]   r_snap;
    logic [1:0]          r_idx;
    logic [W+1:0]        r_sum;
    logic [W-1:0]        r_max;
    logic                w_start_acc;
    logic                w_xfer;
    logic                w_last;
    logic [W-1:0]        w_word;

    // Current word is selected straight from the snapshot by the index.
    assign w_word = r_snap[int'(r_idx) * W +: W];

`ifdef READ_PARITY_EN
    logic [3:0]          r_par_cnt;
    logic [W-1:0]        w_live_word;
    logic                w_par_diff;

    // Live register value for the word being accepted, to spot mid-scan changes.
    assign w_live_word = q_bus[int'(r_idx) * W +: W];
    assign w_par_diff  = (^w_word) != (^w_live_word);
`endif

    // State register.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the strobes that steer the datapath.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next      = S_READ;
                end
            end
            S_READ: begin
                w_xfer = rd_ready;
                w_last = (r_idx == LAST_IDX);
                if (rd_ready && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Snapshot, index and accumulators; the index never passes the last word.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_snap <= '0;
            r_idx  <= 2'd0;
            r_sum  <= '0;
            r_max  <= '0;
        end else if (w_start_acc) begin
            r_snap <= q_bus;
            r_idx  <= 2'd0;
            r_sum  <= '0;
            r_max  <= '0;
        end else if (w_xfer) begin
            r_sum <= r_sum + {2'b00, w_word};
            if (w_word > r_max) begin
                r_max <= w_word;
            end
            if (!w_last) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

`ifdef READ_PARITY_EN
    // Count accepted words whose register changed parity since the snapshot.
    always_ff @(posedge ck) begin
        if (rst || w_start_acc) begin
            r_par_cnt <= 4'd0;
        end else if (w_xfer && w_par_diff && (r_par_cnt != 4'd15)) begin
            r_par_cnt <= r_par_cnt + 4'd1;
        end
    end

    assign rd_par      = ^w_word;
    assign par_err_cnt = r_par_cnt;
`endif

    // Outputs are pure decodes of registered state, so they reset cleanly.
    always_comb begin
        rd_valid  = (r_state == S_READ);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        rd_idx    = r_idx;
        rd_data   = w_word;
        sum       = r_sum;
        max       = r_max;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_registrador_leitor.sv
// Bench for registrador_leitor: table of scans plus hand-written corner
// sequences (ignored start, q_bus change after snapshot, mid-scan reset,
// start held high). Feature macro READ_PARITY_EN enables parity checks.
module tb_registrador_leitor;

    localparam int W    = 6;
    localparam int NREG = 3;

    logic              ck = 1'b0;
    logic              rst;
    logic              start;
    logic [NREG*W-1:0] q_bus;
    logic              rd_ready;
    logic              rd_valid;
    logic [1:0]        rd_idx;
    logic [W-1:0]      rd_data;
    logic              busy;
    logic [W+1:0]      sum;
    logic [W-1:0]      max;
    logic              done;
    logic [1:0]        dbg_state;
`ifdef READ_PARITY_EN
    logic              rd_par;
    logic [3:0]        par_err_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected words in order, each packed as {idx, data}.
    logic [W+1:0] exp_q[$];

    typedef struct {
        logic [NREG*W-1:0] qv;
        logic [NREG*W-1:0] qa;
        logic [3:0]        rdy;
        int                e_sum;
        int                e_max;
        int                e_cyc;
    } vec_t;

    vec_t vecs[8];

    registrador_leitor #(.W(W), .NREG(NREG)) dut (
        .ck          (ck),
        .rst         (rst),
        .start       (start),
        .q_bus       (q_bus),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .busy        (busy),
        .sum         (sum),
        .max         (max),
        .done        (done),
`ifdef READ_PARITY_EN
        .rd_par      (rd_par),
        .par_err_cnt (par_err_cnt),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock.
    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_idx"},   32'(rd_idx), 0);
        check({tag, "_rd_data"},  32'(rd_data), 0);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_sum"},      32'(sum), 0);
        check({tag, "_max"},      32'(max), 0);
        check({tag, "_done"},     32'(done), 0);
`ifdef READ_PARITY_EN
        check({tag, "_rd_par"},   32'(rd_par), 0);
        check({tag, "_par_cnt"},  32'(par_err_cnt), 0);
`endif
    endtask

    // One full scan: snapshot qv, then present qa on q_bus; rd_ready follows rdy.
    task automatic run_scan(input string name, input logic [NREG*W-1:0] qv,
                            input logic [NREG*W-1:0] qa, input logic [3:0] rdy,
                            input int e_sum, input int e_max, input int e_cyc);
        int           cyc;
        int           xf;
        int           e_par;
        logic [W+1:0] e;
        logic [1:0]   kk;
        q_bus    = qv;
        start    = 1'b1;
        rd_ready = 1'b0;
        e_par    = 0;
        for (int k = 0; k < NREG; k++) begin
            kk = 2'(k);
            exp_q.push_back({kk, qv[k*W +: W]});
            if ((^qv[k*W +: W]) != (^qa[k*W +: W]) && e_par < 15) e_par++;
        end
        step();
        start = 1'b0;
        q_bus = qa;
        check({name, "_first_valid"}, 32'(rd_valid), 1);
        check({name, "_busy_on"}, 32'(busy), 1);
        check({name, "_sum_clr"}, 32'(sum), 0);
        cyc = 0;
        xf  = 0;
        while (!done && cyc < 40) begin
            rd_ready = rdy[cyc % 4];
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL %s_extra_word: got idx %0d data %0d, expected none", name, rd_idx, rd_data);
                end else begin
                    e = exp_q[0];
                    check({name, "_idx"}, 32'(rd_idx), 32'(e[W+1:W]));
                    check({name, "_data"}, 32'(rd_data), 32'(e[W-1:0]));
`ifdef READ_PARITY_EN
                    check({name, "_rd_par"}, 32'(rd_par), 32'(^e[W-1:0]));
`endif
                    if (rd_ready) begin
                        void'(exp_q.pop_front());
                        xf++;
                    end
                end
            end
            step();
            cyc++;
        end
        check({name, "_done_seen"}, 32'(done), 1);
        check({name, "_cycles"}, 32'(cyc), 32'(e_cyc));
        check({name, "_valid_off"}, 32'(rd_valid), 0);
        check({name, "_sum"}, 32'(sum), 32'(e_sum));
        check({name, "_max"}, 32'(max), 32'(e_max));
        check({name, "_xfers"}, 32'(xf), 32'(NREG));
        check({name, "_left_in_queue"}, 32'(exp_q.size()), 0);
`ifdef READ_PARITY_EN
        check({name, "_par_cnt"}, 32'(par_err_cnt), 32'(e_par));
`endif
        exp_q.delete();
        rd_ready = 1'b0;
        step();
        check({name, "_done_once"}, 32'(done), 0);
        check({name, "_busy_off"}, 32'(busy), 0);
        check({name, "_sum_held"}, 32'(sum), 32'(e_sum));
        check({name, "_max_held"}, 32'(max), 32'(e_max));
    endtask

    initial begin
        int           dcnt;
        int           xf;
        int           last_done;
        logic [W-1:0] rq [NREG];
        int           rs;
        int           rm;
        logic [NREG*W-1:0] pk;
        logic [NREG*W-1:0] q123;

        rst      = 1'b1;
        start    = 1'b0;
        q_bus    = '0;
        rd_ready = 1'b0;
        q123     = {6'd3, 6'd2, 6'd1};

        // Vector table: fixed cases, then random data computed by a small model.
        vecs[0] = '{q123, q123, 4'b1111, 6, 3, 3};
        vecs[1] = '{{6'd63, 6'd63, 6'd63}, {6'd63, 6'd63, 6'd63}, 4'b1001, 189, 63, 5};
        vecs[2] = '{{6'd10, 6'd40, 6'd5}, {6'd10, 6'd40, 6'd5}, 4'b0101, 55, 40, 5};
        vecs[3] = '{'0, '0, 4'b1111, 0, 0, 3};
        vecs[4] = '{{6'd0, 6'd63, 6'd1}, {6'd0, 6'd63, 6'd1}, 4'b0110, 64, 63, 6};
        for (int v = 5; v < 8; v++) begin
            rs = 0;
            rm = 0;
            for (int k = 0; k < NREG; k++) begin
                rq[k] = 6'($urandom_range(0, 63));
                pk[k*W +: W] = rq[k];
                rs += int'(rq[k]);
                if (int'(rq[k]) > rm) rm = int'(rq[k]);
            end
            vecs[v] = '{pk, pk, 4'b1111, rs, rm, 3};
        end

        step();
        step();
        check_reset_outputs("reset");
        check("reset_state", 32'(dbg_state), 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            run_scan($sformatf("vec%0d", v), vecs[v].qv, vecs[v].qa, vecs[v].rdy,
                     vecs[v].e_sum, vecs[v].e_max, vecs[v].e_cyc);
        end

        // q_bus changes right after the snapshot: the scan still shows 1,2,3.
        run_scan("qchange", q123, {6'd7, 6'd7, 6'd7}, 4'b1111, 6, 3, 3);

        // start pulsed during READ and during DONE is ignored.
        q_bus = q123;
        start = 1'b1;
        step();
        dcnt = 0;
        xf   = 0;
        for (int c = 0; c < 8; c++) begin
            start    = (c == 0 || c == 3);
            rd_ready = 1'b1;
            if (c == 3) check("ign_in_done", 32'(dbg_state), 2);
            if (rd_valid) begin
                check("ign_idx", 32'(rd_idx), 32'(xf));
                check("ign_data", 32'(rd_data), 32'(xf + 1));
                xf++;
            end
            if (done) dcnt++;
            step();
        end
        start = 1'b0;
        check("ign_xfers", 32'(xf), 3);
        check("ign_done_count", 32'(dcnt), 1);
        check("ign_idle", 32'(busy), 0);
        check("ign_sum", 32'(sum), 6);

        // Reset in the middle of a scan discards it.
        q_bus    = q123;
        start    = 1'b1;
        rd_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        check("midrst_idx1", 32'(rd_idx), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midrst");
        run_scan("after_rst", q123, q123, 4'b1111, 6, 3, 3);

        // start held high for 12 cycles: back-to-back scans, done every 5 cycles.
        q_bus     = q123;
        rd_ready  = 1'b1;
        dcnt      = 0;
        xf        = 0;
        last_done = -1;
        for (int c = 0; c < 17; c++) begin
            start = (c < 12);
            if (rd_valid) begin
                check("held_idx", 32'(rd_idx), 32'(xf % NREG));
                check("held_data", 32'(rd_data), 32'((xf % NREG) + 1));
                xf++;
            end
            if (done) begin
                if (last_done >= 0) check("held_done_spacing", 32'(c - last_done), 5);
                last_done = c;
                dcnt++;
            end
            step();
        end
        start = 1'b0;
        check("held_done_count", 32'(dcnt), 3);
        check("held_xfers", 32'(xf), 9);
        check("held_idle", 32'(busy), 0);
        check("held_sum", 32'(sum), 6);
        check("held_max", 32'(max), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
